// File: rtl/mem_arb.sv
// mem_arb: round-robin front end that shares the DDR3 controller's single-request
// port between a random-access read/write client (A) and a FIFO-buffered write stream (B).
module mem_arb #(
    parameter int AW     = 20,
    parameter int DW     = 32,
    parameter int FDEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memreset,
    input  logic          areq,
    input  logic          awr,
    input  logic [AW-1:0] aaddr,
    input  logic [DW-1:0] awdata,
    output logic          aack,
    output logic [DW-1:0] ardata,
    input  logic          bvalid,
    output logic          bready,
    input  logic [AW-1:0] baddr,
    input  logic [DW-1:0] bdata,
    output logic          bbusy,
    output logic [AW-1:0] memaddr,
    output logic          memwr,
    output logic [DW-1:0] memwdata,
    output logic          memreq,
    input  logic          memack,
    input  logic [DW-1:0] memrdata
);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e        state_q, state_d;
    logic          apend_q;
    logic [AW-1:0] hold_addr_q;
    logic          hold_wr_q;
    logic [DW-1:0] hold_wdata_q;
    logic [AW-1:0] fifo_addr_q [FDEPTH];
    logic [DW-1:0] fifo_data_q [FDEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          grant_b_q;
    logic [AW-1:0] memaddr_q;
    logic          memwr_q;
    logic [DW-1:0] memwdata_q;
    logic          memreq_q;
    logic          aack_q;
    logic [DW-1:0] ardata_q;

    logic          a_accept, a_elig, fifo_nonempty, fifo_full;
    logic          push, pop, issue, pick_b, done_a;
    logic [AW-1:0] a_addr;
    logic          a_wr;
    logic [DW-1:0] a_wdata;

    // A request in the same cycle as an idle slot is served straight from the pins.
    assign a_accept      = areq && !apend_q;
    assign a_elig        = apend_q || a_accept;
    assign a_addr        = apend_q ? hold_addr_q  : aaddr;
    assign a_wr          = apend_q ? hold_wr_q    : awr;
    assign a_wdata       = apend_q ? hold_wdata_q : awdata;
    assign fifo_nonempty = (count_q != '0);
    assign fifo_full     = (count_q == CW'(FDEPTH));
    assign push          = bvalid && !fifo_full;

    always_ff @(posedge clk) begin
        // NOTE: registers take <= so every flop samples the pre-edge value of its peers.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!memreset && (a_elig || fifo_nonempty)) state_d = S_WAIT;
            S_WAIT: if (memack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue  = (state_q == S_IDLE) && !memreset && (a_elig || fifo_nonempty);
        pick_b = fifo_nonempty && (!a_elig || !grant_b_q);
        done_a = (state_q == S_WAIT) && memack && !grant_b_q;
        pop    = (state_q == S_WAIT) && memack &&  grant_b_q;
        bready = !fifo_full;
        bbusy  = fifo_nonempty || ((state_q == S_WAIT) && grant_b_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            apend_q      <= 1'b0;
            hold_addr_q  <= '0;
            hold_wr_q    <= 1'b0;
            hold_wdata_q <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            grant_b_q    <= 1'b1;
            memaddr_q    <= '0;
            memwr_q      <= 1'b0;
            memwdata_q   <= '0;
            memreq_q     <= 1'b0;
            aack_q       <= 1'b0;
            ardata_q     <= '0;
        end else begin
            memreq_q <= issue;
            aack_q   <= done_a;
            if (a_accept) begin
                apend_q      <= 1'b1;
                hold_addr_q  <= aaddr;
                hold_wr_q    <= awr;
                hold_wdata_q <= awdata;
            end else if (done_a) begin
                apend_q <= 1'b0;
            end
            if (issue) begin
                grant_b_q <= pick_b;
                if (pick_b) begin
                    memaddr_q  <= fifo_addr_q[rptr_q];
                    memwr_q    <= 1'b1;
                    memwdata_q <= fifo_data_q[rptr_q];
                end else begin
                    memaddr_q  <= a_addr;
                    memwr_q    <= a_wr;
                    memwdata_q <= a_wdata;
                end
            end
            if (done_a && !memwr_q) ardata_q <= memrdata;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= baddr;
            fifo_data_q[wptr_q] <= bdata;
        end
    end

    assign memaddr  = memaddr_q;
    assign memwr    = memwr_q;
    assign memwdata = memwdata_q;
    assign memreq   = memreq_q;
    assign aack     = aack_q;
    assign ardata   = ardata_q;
endmodule
